if_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register; directly upstream of the decode stage.
//  - Holds the PC and drives the instruction-memory request.
//  - Registers instr / PC+4 / valid for ID.
//  - Redirects the PC on a taken BEQ resolved in ID and flushes the wrong-path fetch.
//  - Holds PC and IF/ID on a hazard stall; inserts bubbles while imem is not ready.

---
 rtl/if_stage.sv | 75 +++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, issues fetches, redirects on taken branches and inserts bubbles.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_req_o,
    input  logic [31:0] imem_instr_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_plus4_reg, pc_plus4_next;
    logic        valid_reg, valid_next;
    logic [31:0] pc_inc;

    assign pc_inc = pc_reg + 32'd4;

    // Priority: stall > redirect > fetch > wait. A stall freezes everything,
    // including a pending redirect, since the ID compare is not final yet.
    always_comb begin
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        pc_plus4_next = pc_plus4_reg;
        valid_next    = valid_reg;
        if (!stall_i) begin
            if (branch_taken_i) begin
                pc_next    = branch_target_i;
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
            end else if (imem_ready_i) begin
                pc_next       = pc_inc;
                instr_next    = imem_instr_i;
                pc_plus4_next = pc_inc;
                valid_next    = 1'b1;
            end else begin
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP_INSTR;
            pc_plus4_reg <= 32'd0;
            valid_reg    <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            pc_plus4_reg <= pc_plus4_next;
            valid_reg    <= valid_next;
        end
    end

    assign imem_addr_o = pc_reg;
    assign imem_req_o  = !(rst || stall_i);
    assign pc_o        = pc_reg;
    assign instr_o     = instr_reg;
    assign pc_plus4_o  = pc_plus4_reg;
    assign valid_o     = valid_reg;

endmodule
